gate_logic_pipe: RTL

GATE_LOGIC_PIPE -- requirements
Module: gate_logic_pipe

---
 rtl/gate_logic_pipe.sv | 76 +++++++
 1 files changed

// File: rtl/gate_logic_pipe.sv
// Single-stage valid/ready pipeline that applies a bitwise gate operation to two
// operands and counts completed output transfers.
module gate_logic_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] result_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             drain;

    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign c         = c_q;
    assign xfer_cnt  = cnt_q;

    always_comb begin
        // NOTE: assign a default before the case so every path drives result_d and no latch is inferred.
        result_d = '0;
        case (op)
            3'd0: result_d = a & b;
            3'd1: result_d = a | b;
            3'd2: result_d = a ^ b;
            3'd3: result_d = ~(a & b);
            3'd4: result_d = ~(a | b);
            3'd5: result_d = ~(a ^ b);
            3'd6: result_d[0] = &a;
            3'd7: result_d[0] = |a;
            default: result_d = '0;
        endcase
    end

    // NOTE: reset is synchronous and wins over accept/drain; all state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            c_q     <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                c_q <= result_d;
            end
            if (drain) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            case (state_q)
                EMPTY: if (accept) state_q <= FULL;
                FULL:  if (drain && !accept) state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule
